// File: rtl/pair_gen_fifo.sv
// Small element store that, on start, streams every (i,j) index pair of its
// contents (combinations, combinations-with-self or permutations) over a valid/ready port.
module pair_gen_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic [AW:0]   count,
  input  logic          clear,
  input  logic [1:0]    mode,
  input  logic          start,
  output logic          busy,
  output logic [DW-1:0] dout_a,
  output logic [DW-1:0] dout_b,
  output logic          valid,
  input  logic          ready,
  output logic          last,
  output logic          done
);

  localparam int          DEPTH = 1 << AW;
  localparam logic [AW:0] N_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic [AW:0] TWO   = (AW+1)'(2);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_FETCH, S_RUN, S_EMPTY} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   n_q, i_q, j_q, ni, nj, jp1;
  logic [1:0]    mode_q;
  logic [DW-1:0] a_q, b_q;
  logic          last_q, done_q, done_d;
  logic          idle, wr_acc, is_perm, is_self, no_pairs, pair_last, load, fin;

  assign idle     = (state_q == S_IDLE);
  assign full     = (count_q == N_MAX);
  assign wr_acc   = !rst && idle && wr_en && !full && !clear;
  assign is_perm  = (mode_q == 2'd2);
  assign is_self  = (mode_q == 2'd1);
  assign no_pairs = (n_q == '0) || (!is_self && n_q < TWO);
  assign load     = (state_q == S_FETCH) || (state_q == S_RUN && ready && !last_q);
  assign fin      = (state_q == S_RUN) && ready && last_q;

  always_comb begin
    if (is_perm)      pair_last = (i_q == n_q - ONE) && (j_q == n_q - TWO);
    else if (is_self) pair_last = (i_q == n_q - ONE) && (j_q == n_q - ONE);
    else              pair_last = (i_q == n_q - TWO) && (j_q == n_q - ONE);
  end

  // Successor of (i_q,j_q) in i-outer/j-inner order; permutations skip the diagonal.
  always_comb begin
    jp1 = j_q + ONE;
    ni  = i_q;
    nj  = jp1;
    if (is_perm) begin
      if (jp1 == i_q) nj = j_q + TWO;
      if (nj >= n_q) begin
        ni = i_q + ONE;
        nj = '0;
      end
    end else if (jp1 >= n_q) begin
      ni = i_q + ONE;
      nj = is_self ? i_q + ONE : i_q + TWO;
    end
  end

  always_comb begin
    count_d = count_q;
    if (idle && clear)  count_d = '0;
    else if (wr_acc)    count_d = count_q + ONE;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_PREP;
      S_PREP:  state_d = no_pairs ? S_EMPTY : S_FETCH;
      S_FETCH: state_d = S_RUN;
      S_RUN:   if (fin) begin
                 state_d = S_IDLE;
                 done_d  = 1'b1;
               end
      S_EMPTY: begin
                 state_d = S_IDLE;
                 done_d  = 1'b1;
               end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy   = !idle;
    valid  = (state_q == S_RUN);
    last   = last_q;
    done   = done_q;
    count  = count_q;
    dout_a = a_q;
    dout_b = b_q;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[count_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      n_q     <= '0;
      mode_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q  <= done_d;
      count_q <= count_d;
      if (idle && start) begin
        n_q    <= count_q;
        mode_q <= mode;
      end
      if (state_q == S_PREP) begin
        i_q <= '0;
        j_q <= is_self ? '0 : ONE;
      end
      // Output registers hold the presented pair; i_q/j_q already point at the next one.
      if (load) begin
        a_q    <= mem[i_q[AW-1:0]];
        b_q    <= mem[j_q[AW-1:0]];
        last_q <= pair_last;
        i_q    <= ni;
        j_q    <= nj;
      end else if (fin) begin
        last_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pair_gen_fifo.sv
// Randomized bench for pair_gen_fifo: a queue-based reference model predicts every
// output each cycle; directed runs pin the model with hand-computed pair lists.
module tb_pair_gen_fifo;
  localparam int NMAX = 16;

  logic       clk = 1'b0;
  logic       rst, wr_en, clear, start, ready;
  logic [7:0] din, dout_a, dout_b;
  logic [1:0] mode;
  logic       full, busy, valid, last, done;
  logic [4:0] count;

  pair_gen_fifo #(.DW(8), .AW(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(full), .count(count),
    .clear(clear), .mode(mode), .start(start), .busy(busy), .dout_a(dout_a),
    .dout_b(dout_b), .valid(valid), .ready(ready), .last(last), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0]  m_mem [NMAX];
  int          m_cnt, m_wait, m_pos;
  bit          m_busy, m_done, m_zero;
  int          pa[$], pb[$];
  logic [15:0] hs_log[$];
  int          checks = 0, errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build(logic [1:0] md, int n);
    pa.delete(); pb.delete();
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        if ((md == 2'd2) ? (i != j) : (md == 2'd1) ? (j >= i) : (j > i)) begin
          pa.push_back(i); pb.push_back(j);
        end
  endtask

  task automatic compare();
    bit e_valid;
    e_valid = m_busy && m_wait == 0 && m_pos < pa.size();
    chk("count", 32'(count), 32'(m_cnt));
    chk("full",  32'(full),  32'(m_cnt == NMAX));
    chk("busy",  32'(busy),  32'(m_busy));
    chk("valid", 32'(valid), 32'(e_valid));
    chk("last",  32'(last),  32'(e_valid && m_pos == pa.size() - 1));
    chk("done",  32'(done),  32'(m_done));
    if (e_valid) begin
      chk("dout_a", 32'(dout_a), 32'(m_mem[pa[m_pos]]));
      chk("dout_b", 32'(dout_b), 32'(m_mem[pb[m_pos]]));
    end else if (m_zero) begin
      chk("dout_rst", 32'({dout_a, dout_b}), 32'd0);
    end
  endtask

  task automatic model_step(bit r, bit w, logic [7:0] d, bit c, logic [1:0] md, bit s, bit rd);
    int n;
    if (r) begin
      m_cnt = 0; m_busy = 0; m_wait = 0; m_pos = 0; m_done = 0; m_zero = 1;
      pa.delete(); pb.delete();
      return;
    end
    m_done = 0;
    if (m_busy) begin
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          if (pa.size() == 0) begin m_busy = 0; m_done = 1; end
          else m_zero = 0;
        end
      end else if (rd) begin
        m_pos++;
        if (m_pos == pa.size()) begin m_busy = 0; m_done = 1; end
      end
    end else begin
      n = m_cnt;
      if (c) m_cnt = 0;
      else if (w && m_cnt < NMAX) begin m_mem[m_cnt] = d; m_cnt++; end
      if (s) begin build(md, n); m_busy = 1; m_wait = 2; m_pos = 0; end
    end
  endtask

  task automatic cyc(bit r, bit w, logic [7:0] d, bit c, logic [1:0] md, bit s, bit rd);
    @(negedge clk);
    compare();
    rst = r; wr_en = w; din = d; clear = c; mode = md; start = s; ready = rd;
    if (valid === 1'b1 && rd) hs_log.push_back({dout_a, dout_b});
    model_step(r, w, d, c, md, s, rd);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 8'h0, 0, 2'd0, 0, 1);
  endtask

  task automatic wr(logic [7:0] d);
    cyc(0, 1, d, 0, 2'd0, 0, 1);
  endtask

  // rpat: 0 ready high, 1 ready 1,0,0,1 repeating, 2 random; junk writes/clears while busy
  task automatic run_enum(logic [1:0] md, int rpat);
    int k;
    bit rd;
    hs_log.delete();
    cyc(0, 0, 8'h0, 0, md, 1, 1);
    k = 0;
    while (m_busy && k < 2000) begin
      rd = (rpat == 0) ? 1'b1 : (rpat == 1) ? (k % 4 == 0 || k % 4 == 3) : 1'($urandom_range(0, 1));
      cyc(0, 1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rd);
      k++;
    end
    if (m_busy) begin
      checks++; errors++;
      $display("FAIL enum_timeout mode %0d still busy after %0d cycles", md, k);
    end
    idle(1);
  endtask

  initial begin
    logic [15:0] m0 [6];
    int k;
    m0[0] = 16'h1122; m0[1] = 16'h1133; m0[2] = 16'h1144;
    m0[3] = 16'h2233; m0[4] = 16'h2244; m0[5] = 16'h3344;
    rst = 1; wr_en = 0; din = 0; clear = 0; mode = 0; start = 0; ready = 0;
    repeat (2) @(posedge clk);
    model_step(1, 0, 8'h0, 0, 2'd0, 0, 0);
    idle(2);

    wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
    run_enum(2'd0, 0);
    chk("m0_pairs", hs_log.size(), 6);
    if (hs_log.size() == 6) begin
      chk("m0_first", 32'(hs_log[0]), 32'h1122);
      chk("m0_third", 32'(hs_log[2]), 32'h1144);
      chk("m0_last",  32'(hs_log[5]), 32'h3344);
    end
    run_enum(2'd2, 0);
    chk("m2_pairs", hs_log.size(), 12);
    if (hs_log.size() == 12) begin
      chk("m2_fourth", 32'(hs_log[3]), 32'h2211);
      chk("m2_last",   32'(hs_log[11]), 32'h4433);
    end
    run_enum(2'd1, 0);
    chk("m1_pairs", hs_log.size(), 10);
    if (hs_log.size() == 10) begin
      chk("m1_first", 32'(hs_log[0]), 32'h1111);
      chk("m1_last",  32'(hs_log[9]), 32'h4444);
    end
    run_enum(2'd3, 1);
    chk("m3_toggle_pairs", hs_log.size(), 6);
    if (hs_log.size() == 6)
      for (int i = 0; i < 6; i++) chk("m3_toggle_seq", 32'(hs_log[i]), 32'(m0[i]));

    // reset in the middle of an enumeration
    hs_log.delete();
    cyc(0, 0, 8'h0, 0, 2'd0, 1, 1);
    k = 0;
    while (hs_log.size() < 3 && k < 50) begin
      cyc(0, 1, 8'h5A, 1, 2'd0, 0, 1);
      k++;
    end
    chk("rst_mid_hs", hs_log.size(), 3);
    cyc(1, 0, 8'h0, 0, 2'd0, 0, 1);
    idle(5);
    chk("rst_mid_count", 32'(count), 32'd0);

    // fill past capacity
    for (int i = 0; i < NMAX + 1; i++) wr(8'(i * 7 + 1));
    idle(1);
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_full",  32'(full),  32'd1);
    run_enum(2'd0, 2);
    chk("full_m0_pairs", hs_log.size(), 120);
    run_enum(2'd2, 2);
    chk("full_m2_pairs", hs_log.size(), 240);

    // single element
    cyc(0, 0, 8'h0, 1, 2'd0, 0, 1);
    wr(8'hA1);
    run_enum(2'd0, 0);
    chk("n1_m0_pairs", hs_log.size(), 0);
    run_enum(2'd1, 0);
    chk("n1_m1_pairs", hs_log.size(), 1);
    if (hs_log.size() == 1) chk("n1_m1_pair", 32'(hs_log[0]), 32'hA1A1);

    // free-running random traffic
    for (int i = 0; i < 1500; i++)
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) != 0), 8'($urandom),
          ($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
